// File: rtl/lmem_arbiter.sv
// Layer-memory port arbiter: shares one memory command port between NREQ engines.
// Round-robin grant with an optional burst lock; registered command outputs and
// a registered read-return path steered to the requester that issued the read.
// Define LMEM_ARB_STATS_EN to add saturating stall/grant counters.
module lmem_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 12,
  parameter int unsigned DW   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [3*NREQ-1:0]    req_sel,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic [DW*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        rdata,
  output logic [NREQ-1:0]      rvalid,
  output logic                 sel_err,
  output logic                 cwr,
  output logic                 crd,
  output logic [AW-1:0]        caddr_wr,
  output logic [AW-1:0]        caddr_rd,
  output logic [DW-1:0]        cdata_wr,
  output logic [2:0]           csel,
  input  logic [DW-1:0]        cdata_rd
`ifdef LMEM_ARB_STATS_EN
  ,
  output logic [15:0]          stall_cnt,
  output logic [16*NREQ-1:0]   grant_cnt
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StOpen, StLock} state_e;

  state_e          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;

  logic [2:0]      sel_a   [NREQ];
  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];

  logic [NREQ-1:0] elig_base;
  logic [NREQ-1:0] elig;
  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic [PW-1:0]   rr_next;
  logic [NREQ-1:0] owner_oh;
  logic [2:0]      win_sel;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            win_we;
  logic            win_lock;

  // Unpack the flat per-requester command buses.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      sel_a[i]   = req_sel[3*i +: 3];
      addr_a[i]  = req_addr[AW*i +: AW];
      wdata_a[i] = req_wdata[DW*i +: DW];
    end
  end

  // Eligibility: a requester granted this cycle sits out; a lock admits only the owner.
  always_comb begin
    elig_base = req & ~gnt;
    if (state == StLock) begin
      elig        = '0;
      elig[owner] = elig_base[owner];
    end else begin
      elig = elig_base;
    end
  end

  // Round-robin pick: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    int            tmp;
    logic [PW-1:0] idx;
    win_valid = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    tmp       = 0;
    idx       = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      tmp = int'(rr_ptr) + k;
      if (tmp >= int'(NREQ)) tmp = tmp - int'(NREQ);
      idx = PW'(tmp);
      if (!win_valid && elig[idx]) begin
        win_valid   = 1'b1;
        win_idx     = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

  // Winner's command fields, next pointer and owner one-hot for read return.
  always_comb begin
    win_sel         = sel_a[win_idx];
    win_addr        = addr_a[win_idx];
    win_wdata       = wdata_a[win_idx];
    win_we          = req_we[win_idx];
    win_lock        = req_lock[win_idx];
    rr_next         = (int'(win_idx) == int'(NREQ) - 1) ? '0 : win_idx + PW'(1);
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // Arbitration FSM, registered memory command and read-return path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      rr_ptr   <= '0;
      owner    <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      sel_err  <= 1'b0;
      cwr      <= 1'b0;
      crd      <= 1'b0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      csel     <= '0;
    end else begin
      // Read data is on cdata_rd during the crd cycle; return it one cycle later.
      rvalid <= crd ? owner_oh : '0;
      if (crd) rdata <= cdata_rd;

      if (win_valid) begin
        gnt     <= win_oh;
        owner   <= win_idx;
        csel    <= win_sel;
        sel_err <= (win_sel == 3'd0);
        if (win_we) begin
          // sel==0 still consumes the grant but never strobes the memory.
          cwr      <= (win_sel != 3'd0);
          crd      <= 1'b0;
          caddr_wr <= win_addr;
          cdata_wr <= win_wdata;
        end else begin
          cwr      <= 1'b0;
          crd      <= (win_sel != 3'd0);
          caddr_rd <= win_addr;
        end
        // Grants inside a lock leave the pointer alone, except the unlocking one.
        if (state != StLock || !win_lock) rr_ptr <= rr_next;
        state <= win_lock ? StLock : StOpen;
      end else begin
        gnt     <= '0;
        cwr     <= 1'b0;
        crd     <= 1'b0;
        sel_err <= 1'b0;
        if (state == StLock) begin
          if (!req[owner]) state <= StIdle;
        end else begin
          state <= StIdle;
        end
      end
    end
  end

`ifdef LMEM_ARB_STATS_EN
  logic stall;
  assign stall = |(elig_base & ~win_oh);

  // Saturating stall and per-requester grant counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (win_oh[i] && grant_cnt[16*i +: 16] != 16'hFFFF) begin
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/lmem_arbiter.md
Name: lmem_arbiter

Overview:
- Shares the single layer-memory port (cwr/crd/caddr_wr/caddr_rd/cdata_wr/csel/cdata_rd) between NREQ engine requesters (conv, max-pool, flatten).
- Round-robin arbitration with an optional burst lock, so a max-pool engine can keep the port for its 4-read/2-write window.
- Registered memory command outputs; read data is returned to the owning requester with a valid strobe.

Parameters:
- NREQ, 3, number of requesters; index 0 has highest priority after reset.
- AW, 12, memory address width.
- DW, 20, memory data width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester access request; held with its command until granted.
- req_we  input  NREQ  1 = write, 0 = read.
- req_lock  input  NREQ  hold the port after this grant.
- req_sel  input  3*NREQ  target memory select, slice i for requester i.
- req_addr  input  AW*NREQ  access address.
- req_wdata  input  DW*NREQ  write data.
- gnt  output  NREQ  one-hot, high the cycle the command is on the memory bus.
- rdata  output  DW  registered read data, shared by all requesters.
- rvalid  output  NREQ  one-hot, rdata valid for requester i.
- sel_err  output  1  one-cycle pulse when a granted command has sel==0.
- cwr  output  1  memory write enable.
- crd  output  1  memory read enable.
- caddr_wr  output  AW  write address.
- caddr_rd  output  AW  read address.
- cdata_wr  output  DW  write data.
- csel  output  3  memory select.
- cdata_rd  input  DW  memory read data; valid combinationally in the cycle crd is high.

Behaviour:
- Reset (reset low, async): gnt=0, rvalid=0, sel_err=0, cwr=0, crd=0, caddr_wr=0, caddr_rd=0, cdata_wr=0, csel=0, rdata=0, rr_ptr=0, owner=0, state=S_IDLE.
- Eligibility: requester i is eligible when req[i]=1 and gnt[i]=0 in the current cycle. A requester is never granted two consecutive cycles for the same held command; it updates its command on the edge that ends its gnt cycle.
- Round-robin: the winner is the first eligible index at or after rr_ptr, wrapping at NREQ-1 to 0. On grant of i, rr_ptr <= (i+1) mod NREQ.
- Issue, registered at edge t+1 for a winner chosen in cycle t:
  - gnt[i]=1 and csel=req_sel[i].
  - Write: cwr=1, crd=0, caddr_wr and cdata_wr loaded.
  - Read: crd=1, cwr=0, caddr_rd loaded.
  - The unused address/data registers hold their values.
- Idle cycle: cwr=0, crd=0, gnt=0; csel and addresses hold.
- Read return: in the cycle crd=1, cdata_rd is captured into rdata, and rvalid[owner] is high the following cycle. Read latency = 2 cycles from request to rvalid when uncontended.
- sel==0 command: granted normally, but cwr=crd=0 for that cycle, sel_err pulses, and no rvalid.
- FSM states:
  - S_IDLE: no command on bus. Any eligible request goes to S_OPEN, or to S_LOCK if the winner's req_lock=1.
  - S_OPEN: unlocked command on bus. Next state is S_OPEN on a new grant, S_LOCK on a grant with lock, S_IDLE if nothing is eligible.
  - S_LOCK: only owner is eligible; other requests wait regardless of rr_ptr. Stay while req_lock[owner]=1. When owner issues a command with req_lock[owner]=0, that command is granted and the FSM goes to S_OPEN. If req[owner] drops while locked, release to S_IDLE with no grant that cycle.
  - rr_ptr is not advanced by grants inside S_LOCK, except on the final unlocking grant.
- Throughput: at most one memory access per cycle. A single requester achieves one access per 2 cycles; two requesters alternating achieve one per cycle.
- Simultaneous events: a read return and a new grant in the same cycle are independent. rvalid and gnt may both be high for different or the same requester.
- Reset asserted mid-access: the in-flight read is dropped with no rvalid, and the bus returns to idle immediately.

Optional Feature:
- Macro LMEM_ARB_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt (16-bit): saturating count of cycles in which at least one eligible requester was not granted.
  - grant_cnt (16*NREQ): per-requester saturating grant counts.
  - All counters reset to 0 and stick at 16'hFFFF.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Single read: req[0], req_we=0, sel=1, addr=12'h041, memory returns 20'h00ABC → gnt[0] in the cycle after req; crd=1, caddr_rd=12'h041, csel=1; rvalid[0] one cycle later with rdata=20'h00ABC.
- Contention: req[0..2] all held (writes to 12'h100, 12'h200, 12'h300) → grants in order 0,1,2 on consecutive cycles, then 0 again; caddr_wr sequence 100,200,300.
- Lock burst: req[1] with lock for 4 reads at 12'h000, 001, 040, 041, with req[0] pending → no gnt[0] until req[1]'s unlocking grant; gnt[0] on the next cycle.
- sel==0 write from requester 2 → gnt[2]=1, cwr=0, sel_err pulses for 1 cycle.
- Reset low during a read cycle (crd=1) → all outputs 0 asynchronously; no rvalid after release; first post-reset grant goes to index 0.
- With LMEM_ARB_STATS_EN: 3 requesters contending for 6 cycles → stall_cnt=6, grant_cnt=2 each.
